// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ----------------------------------------------------------------------------
// Receive-side byte buffer between uart_rx and mem_ctl. Every in_valid strobe
// is captured into a DEPTH-entry circular buffer. The oldest byte is presented
// first-word-fall-through on rd_data. The block also reports the fill level,
// a sticky overrun flag and a level threshold interrupt.
//
// Optional feature macro: UART_RX_FIFO_BREAK_EN
//   defined   : each entry also stores in_break, and rd_break reports the
//               head entry's tag.
//   undefined : entries are 8 bits wide, in_break is ignored, rd_break = 0.
//
// Parameters
//   DEPTH       number of entries, power of two, 2..256
//   THRESHOLD   irq asserts when count >= THRESHOLD, 1..DEPTH
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   in_valid     one-cycle byte strobe from the receiver
//   in_data      received byte, sampled with in_valid
//   in_break     break indication, sampled with in_valid
//   rd_en        pop strobe from mem_ctl, one cycle per byte
//   rd_valid     buffer non-empty
//   rd_data      head byte, 8'h00 while empty
//   rd_break     head entry break tag, 0 while empty or when compiled out
//   full         count == DEPTH
//   count        fill level 0..DEPTH
//   overrun      sticky, set when a byte is dropped
//   clr_overrun  one-cycle clear of overrun (a same-cycle set wins)
//   irq          level, count >= THRESHOLD
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    input  logic                       in_break,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [7:0]                 rd_data,
    output logic                       rd_break,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    input  logic                       clr_overrun,
    output logic                       irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESHOLD);

`ifdef UART_RX_FIFO_BREAK_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;

    logic wr_accept;
    logic rd_accept;
    logic drop;

    // While full, a same-cycle pop frees the slot being written, so both
    // operations proceed and the level stays at DEPTH.
    assign rd_accept = rd_en && (count != '0);
    assign wr_accept = in_valid && ((count != DEPTH_C) || rd_en);
    assign drop      = in_valid && !wr_accept;

`ifdef UART_RX_FIFO_BREAK_EN
    assign wr_entry = {in_break, in_data};
`else
    logic unused_in_break;
    assign unused_in_break = in_break;
    assign wr_entry        = in_data;
`endif

    // NOTE: the storage array has no reset; its contents are never visible
    // while the buffer is empty, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wp] <= wr_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_accept) begin
                wp <= wp + 1'b1;
            end
            if (rd_accept) begin
                rp <= rp + 1'b1;
            end

            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Outputs decode from registered state only; no input reaches them.
    assign head_entry = mem[rp];
    assign rd_valid   = (count != '0);
    assign full       = (count == DEPTH_C);
    assign irq        = (count >= THRESH_C);
    assign rd_data    = rd_valid ? head_entry[7:0] : 8'h00;

`ifdef UART_RX_FIFO_BREAK_EN
    assign rd_break = rd_valid & head_entry[8];
`else
    assign rd_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for uart_rx_fifo (DEPTH=16, THRESHOLD=8). A queue-based
// model tracks the expected buffer contents and overrun flag; a compare
// process checks every output against it on each falling edge. Directed
// sequences pin the model with literal expectations, followed by randomized
// traffic with occasional resets. Honours UART_RX_FIFO_BREAK_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH     = 16;
    localparam int THRESHOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_break;
    logic       rd_en;
    logic       clr_overrun;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_break;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_break    (in_break),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_break    (rd_break),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each queue entry is {break, data}.
    logic [8:0] model_q[$];
    logic       model_ovr = 1'b0;
    bit         cmp_en    = 1'b0;

    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (!rst_n) begin
            model_q.delete();
            model_ovr = 1'b0;
            cmp_en    = 1'b1;
        end else begin
            rd_ok = rd_en && (model_q.size() > 0);
            wr_ok = in_valid && ((model_q.size() < DEPTH) || rd_en);
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back({in_break, in_data});
            if (in_valid && !wr_ok) model_ovr = 1'b1;
            else if (clr_overrun)   model_ovr = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            int  n;
            logic [7:0] e_data;
            logic       e_brk;
            n      = model_q.size();
            e_data = (n > 0) ? model_q[0][7:0] : 8'h00;
`ifdef UART_RX_FIFO_BREAK_EN
            e_brk  = (n > 0) ? model_q[0][8] : 1'b0;
`else
            e_brk  = 1'b0;
`endif
            check("cmp_count",    32'(count),    32'(n));
            check("cmp_rd_valid", 32'(rd_valid), 32'(n > 0));
            check("cmp_rd_data",  32'(rd_data),  32'(e_data));
            check("cmp_rd_break", 32'(rd_break), 32'(e_brk));
            check("cmp_full",     32'(full),     32'(n == DEPTH));
            check("cmp_irq",      32'(irq),      32'(n >= THRESHOLD));
            check("cmp_overrun",  32'(overrun),  32'(model_ovr));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply one cycle of inputs, then return 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic b,
                        input logic r, input logic c);
        in_valid    = v;
        in_data     = d;
        in_break    = b;
        rd_en       = r;
        clr_overrun = c;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        in_break    = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_break    = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;

        // Reset; a byte offered during reset must be discarded.
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("rst_count",    32'(count),    32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'h00);
        check("rst_rd_break", 32'(rd_break), 32'd0);
        check("rst_full",     32'(full),     32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        check("rst_irq",      32'(irq),      32'd0);

        // Pops while empty are ignored.
        pop();
        pop();
        check("empty_pop_count", 32'(count), 32'd0);

        // Ordered write / read of three bytes.
        wr(8'h41);
        check("wr1_latency_valid", 32'(rd_valid), 32'd1);
        check("wr1_latency_data",  32'(rd_data),  32'h41);
        wr(8'h42);
        wr(8'h43);
        check("three_count", 32'(count),   32'd3);
        check("three_head",  32'(rd_data), 32'h41);
        pop();
        check("pop1_data",  32'(rd_data), 32'h42);
        check("pop1_count", 32'(count),   32'd2);
        pop();
        check("pop2_data", 32'(rd_data), 32'h43);
        pop();
        check("pop3_valid", 32'(rd_valid), 32'd0);
        check("pop3_count", 32'(count),    32'd0);
        check("pop3_data",  32'(rd_data),  32'h00);

        // Overfill: 17 bytes into 16 entries.
        for (int i = 0; i < 17; i++) begin
            wr(8'(i));
            if (i == 15) check("fill16_full", 32'(full), 32'd1);
            if (i == 15) check("fill16_ovr",  32'(overrun), 32'd0);
            if (i == 16) check("fill17_ovr",  32'(overrun), 32'd1);
            if (i == 16) check("fill17_count", 32'(count), 32'd16);
        end
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(rd_data), 32'(i));
            pop();
        end
        check("drain_count",   32'(count),   32'd0);
        check("drain_ovr_sticky", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_overrun", 32'(overrun), 32'd0);

        // Full with simultaneous write and pop.
        for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        check("full_rw_count", 32'(count),   32'd16);
        check("full_rw_ovr",   32'(overrun), 32'd0);
        check("full_rw_head",  32'(rd_data), 32'h81);
        for (int i = 0; i < 15; i++) pop();
        check("wrap_last", 32'(rd_data), 32'hAA);
        pop();
        check("wrap_empty", 32'(count), 32'd0);

        // Threshold interrupt.
        for (int i = 0; i < 7; i++) wr(8'h10 + 8'(i));
        check("irq_at7", 32'(irq), 32'd0);
        wr(8'h17);
        check("irq_at8", 32'(irq), 32'd1);
        pop();
        check("irq_pop", 32'(irq), 32'd0);
        for (int i = 0; i < 7; i++) pop();
        check("irq_drain", 32'(count), 32'd0);

        // Simultaneous write and pop on an empty buffer.
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        check("empty_rw_count", 32'(count),   32'd1);
        check("empty_rw_data",  32'(rd_data), 32'h5A);
        pop();

        // Break tag.
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        wr(8'h55);
`ifdef UART_RX_FIFO_BREAK_EN
        check("brk_head_tag",  32'(rd_break), 32'd1);
        check("brk_head_data", 32'(rd_data),  32'h00);
        pop();
        check("brk_next_tag",  32'(rd_break), 32'd0);
        check("brk_next_data", 32'(rd_data),  32'h55);
`else
        check("nobrk_head_tag", 32'(rd_break), 32'd0);
        pop();
        check("nobrk_next_data", 32'(rd_data), 32'h55);
`endif
        pop();

        // Randomized traffic in phases of varying write/read bias.
        for (int ph = 0; ph < 12; ph++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
            rd_pct = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 70 : 50;
            for (int c = 0; c < 250; c++) begin
                logic v, b, r, cl;
                logic [7:0] d;
                v  = ($urandom_range(99) < wr_pct);
                r  = ($urandom_range(99) < rd_pct);
                cl = ($urandom_range(99) < 5);
                b  = ($urandom_range(99) < 20);
                d  = 8'($urandom);
                rst_n = ($urandom_range(599) != 0);
                step(v, d, b, r, cl);
                rst_n = 1'b1;
            end
        end

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
